// File: rtl/lsu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : lsu_pkg
// Brief    : Shared constants, request record and decode helpers for the LSU.
// Revision : 1.0  initial release
// ============================================================================
package lsu_pkg;

    localparam logic [1:0] LSU_STATE_IDLE      = 2'd0;
    localparam logic [1:0] LSU_STATE_REQ       = 2'd1;
    localparam logic [1:0] LSU_STATE_WAIT_RESP = 2'd2;
    localparam logic [1:0] LSU_STATE_DONE      = 2'd3;

    localparam logic [2:0] INST_FUNCT3_LB  = 3'b000;
    localparam logic [2:0] INST_FUNCT3_LH  = 3'b001;
    localparam logic [2:0] INST_FUNCT3_LW  = 3'b010;
    localparam logic [2:0] INST_FUNCT3_LBU = 3'b100;
    localparam logic [2:0] INST_FUNCT3_LHU = 3'b101;
    localparam logic [2:0] INST_FUNCT3_SB  = 3'b000;
    localparam logic [2:0] INST_FUNCT3_SH  = 3'b001;
    localparam logic [2:0] INST_FUNCT3_SW  = 3'b010;

    typedef struct packed {
        logic        is_load;
        logic [31:0] addr;
        logic [31:0] data;
        logic [4:0]  rd;
        logic [2:0]  funct3;
    } lsu_req_t;

    // Unsigned widths exist only for loads; stores accept B/H/W.
    function automatic logic f3_valid(input logic is_load, input logic [2:0] f3);
        case (f3)
            INST_FUNCT3_LB, INST_FUNCT3_LH, INST_FUNCT3_LW: f3_valid = 1'b1;
            INST_FUNCT3_LBU, INST_FUNCT3_LHU:              f3_valid = is_load;
            default:                                       f3_valid = 1'b0;
        endcase
    endfunction

    function automatic logic f3_misaligned(input logic [2:0] f3, input logic [1:0] a);
        case (f3[1:0])
            2'b01:   f3_misaligned = a[0];
            2'b10:   f3_misaligned = (a != 2'b00);
            default: f3_misaligned = 1'b0;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/lsu_if.sv
`default_nettype none
// ============================================================================
// Module   : lsu_if
// Brief    : Data-bus request/response bundle between the LSU and memory.
// Revision : 1.0  initial release
// ============================================================================
interface lsu_if;
    logic        dbus_req_valid;
    logic        dbus_req_ready;
    logic        dbus_req_we;
    logic [31:0] dbus_req_addr;
    logic [31:0] dbus_req_wdata;
    logic [3:0]  dbus_req_wstrb;
    logic        dbus_resp_valid;
    logic [31:0] dbus_resp_rdata;

    modport master (
        output dbus_req_valid, dbus_req_we, dbus_req_addr, dbus_req_wdata, dbus_req_wstrb,
        input  dbus_req_ready, dbus_resp_valid, dbus_resp_rdata
    );

    modport slave (
        input  dbus_req_valid, dbus_req_we, dbus_req_addr, dbus_req_wdata, dbus_req_wstrb,
        output dbus_req_ready, dbus_resp_valid, dbus_resp_rdata
    );
endinterface
`default_nettype wire

// File: rtl/lsu_align.sv
`default_nettype none
// ============================================================================
// Module   : lsu_align
// Brief    : Combinational store lane replication/strobes and load extraction.
// Revision : 1.0  initial release
// ============================================================================
module lsu_align
    import lsu_pkg::*;
(
    input  wire  [2:0]  i_funct3,
    input  wire  [1:0]  i_addr_lo,
    input  wire  [31:0] i_store_data,
    input  wire  [31:0] i_load_word,
    output logic [3:0]  o_wstrb,
    output logic [31:0] o_wdata,
    output logic [31:0] o_load_data
);

    logic [31:0] w_shifted;
    logic [7:0]  w_byte;
    logic [15:0] w_half;

    assign w_shifted = i_load_word >> {i_addr_lo, 3'b000};
    assign w_byte    = w_shifted[7:0];
    assign w_half    = i_addr_lo[1] ? i_load_word[31:16] : i_load_word[15:0];

    always_comb begin
        o_wstrb = 4'b1111;
        o_wdata = i_store_data;
        case (i_funct3[1:0])
            2'b00: begin
                o_wstrb = 4'b0001 << i_addr_lo;
                o_wdata = {4{i_store_data[7:0]}};
            end
            2'b01: begin
                o_wstrb = 4'b0011 << {i_addr_lo[1], 1'b0};
                o_wdata = {2{i_store_data[15:0]}};
            end
            default: ;
        endcase
    end

    always_comb begin
        o_load_data = i_load_word;
        case (i_funct3)
            INST_FUNCT3_LB:  o_load_data = {{24{w_byte[7]}}, w_byte};
            INST_FUNCT3_LBU: o_load_data = {24'd0, w_byte};
            INST_FUNCT3_LH:  o_load_data = {{16{w_half[15]}}, w_half};
            INST_FUNCT3_LHU: o_load_data = {16'd0, w_half};
            default: ;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/lsu.sv
`default_nettype none
// ============================================================================
// Module   : lsu
// Brief    : Load/store unit: runs one captured ex request on the data bus,
//            writes load results back and stalls the pipeline while busy.
//            Optional misalignment trap: RUA_LSU_MISALIGN_TRAP_EN.
// Revision : 1.0  initial release
// ============================================================================
module lsu
    import lsu_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 256
) (
    input  wire         clk,
    input  wire         rst,
    lsu_if.master       dbus,
    input  wire         mem_load_en,
    input  wire  [31:0] mem_load_addr,
    input  wire  [4:0]  mem_load_regs_addr,
    input  wire         mem_store_en,
    input  wire  [31:0] mem_store_addr,
    input  wire  [31:0] mem_store_data,
    input  wire  [2:0]  mem_funct3,
    output logic        regs_write_en,
    output logic [4:0]  regs_write_addr,
    output logic [31:0] regs_write_data,
    output logic        pause_signal,
    output logic        unpause_signal,
    output logic        bus_error
`ifdef RUA_LSU_MISALIGN_TRAP_EN
    ,
    output logic        misalign,
    output logic [31:0] misalign_addr
`endif
);

    logic [1:0]  r_state;
    logic [1:0]  w_state_nxt;
    lsu_req_t    r_req;
    logic        r_no_wb;
    logic        r_misalign;
    logic [31:0] r_rdata;

    logic        w_req_any;
    logic [31:0] w_in_addr;
    logic        w_in_f3_ok;
    logic        w_in_mis;
    logic        w_in_ok;
    logic        w_busy;
    logic        w_req_phase;
    logic        w_wdog_hit;
    logic        w_timeout;
    logic [3:0]  w_wstrb;
    logic [31:0] w_wdata;
    logic [31:0] w_load_data;

    // Load has priority when both requests arrive together.
    assign w_req_any  = mem_load_en | mem_store_en;
    assign w_in_addr  = mem_load_en ? mem_load_addr : mem_store_addr;
    assign w_in_f3_ok = f3_valid(mem_load_en, mem_funct3);
`ifdef RUA_LSU_MISALIGN_TRAP_EN
    assign w_in_mis   = w_in_f3_ok && f3_misaligned(mem_funct3, w_in_addr[1:0]);
`else
    assign w_in_mis   = 1'b0;
`endif
    assign w_in_ok    = w_in_f3_ok && !w_in_mis;

    assign w_req_phase = (r_state == LSU_STATE_REQ);
    assign w_busy      = w_req_phase || (r_state == LSU_STATE_WAIT_RESP);

    always_comb begin
        w_state_nxt = r_state;
        w_timeout   = 1'b0;
        case (r_state)
            LSU_STATE_IDLE:
                if (w_req_any) w_state_nxt = w_in_ok ? LSU_STATE_REQ : LSU_STATE_DONE;
            LSU_STATE_REQ:
                if (dbus.dbus_req_ready)
                    w_state_nxt = r_req.is_load ? LSU_STATE_WAIT_RESP : LSU_STATE_DONE;
            LSU_STATE_WAIT_RESP:
                if (dbus.dbus_resp_valid) w_state_nxt = LSU_STATE_DONE;
            default:
                w_state_nxt = LSU_STATE_IDLE;
        endcase
        // A timeout only overrides an access that is not finishing this cycle.
        if (w_wdog_hit && (w_state_nxt != LSU_STATE_DONE)) begin
            w_timeout   = 1'b1;
            w_state_nxt = LSU_STATE_DONE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= LSU_STATE_IDLE;
            r_req      <= '0;
            r_no_wb    <= 1'b0;
            r_misalign <= 1'b0;
            r_rdata    <= 32'd0;
        end else begin
            r_state <= w_state_nxt;
            if ((r_state == LSU_STATE_IDLE) && w_req_any) begin
                r_req.is_load <= mem_load_en;
                r_req.addr    <= w_in_addr;
                r_req.data    <= mem_store_data;
                r_req.rd      <= mem_load_regs_addr;
                r_req.funct3  <= mem_funct3;
                r_no_wb       <= !w_in_ok;
                r_misalign    <= w_in_mis;
            end
            if (w_timeout) r_no_wb <= 1'b1;
            if ((r_state == LSU_STATE_WAIT_RESP) && dbus.dbus_resp_valid)
                r_rdata <= dbus.dbus_resp_rdata;
        end
    end

    generate
        if (TIMEOUT_CYCLES > 0) begin : g_wdog
            localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
            logic [CW-1:0] r_wdog_cnt;

            always_ff @(posedge clk) begin
                if (rst)
                    r_wdog_cnt <= '0;
                else if (w_busy && ((w_state_nxt == LSU_STATE_REQ) ||
                                    (w_state_nxt == LSU_STATE_WAIT_RESP)))
                    r_wdog_cnt <= r_wdog_cnt + CW'(1);
                else
                    r_wdog_cnt <= '0;
            end

            assign w_wdog_hit = w_busy && (r_wdog_cnt == CW'(TIMEOUT_CYCLES - 1));
        end else begin : g_no_wdog
            assign w_wdog_hit = 1'b0;
        end
    endgenerate

    lsu_align u_align (
        .i_funct3     (r_req.funct3),
        .i_addr_lo    (r_req.addr[1:0]),
        .i_store_data (r_req.data),
        .i_load_word  (r_rdata),
        .o_wstrb      (w_wstrb),
        .o_wdata      (w_wdata),
        .o_load_data  (w_load_data)
    );

    assign dbus.dbus_req_valid = w_req_phase;
    assign dbus.dbus_req_we    = w_req_phase && !r_req.is_load;
    assign dbus.dbus_req_addr  = w_req_phase ? {r_req.addr[31:2], 2'b00} : 32'd0;
    assign dbus.dbus_req_wdata = dbus.dbus_req_we ? w_wdata : 32'd0;
    assign dbus.dbus_req_wstrb = dbus.dbus_req_we ? w_wstrb : 4'd0;

    assign pause_signal    = ((r_state == LSU_STATE_IDLE) && w_req_any) || w_busy;
    assign unpause_signal  = (r_state == LSU_STATE_DONE);
    assign bus_error       = w_timeout;
    assign regs_write_en   = unpause_signal && r_req.is_load && (r_req.rd != 5'd0) && !r_no_wb;
    assign regs_write_addr = regs_write_en ? r_req.rd : 5'd0;
    assign regs_write_data = regs_write_en ? w_load_data : 32'd0;

`ifdef RUA_LSU_MISALIGN_TRAP_EN
    assign misalign      = unpause_signal && r_misalign;
    assign misalign_addr = misalign ? r_req.addr : 32'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_lsu.sv
`default_nettype none
// ============================================================================
// Module   : tb_lsu
// Brief    : Directed self-checking bench for lsu (watchdog limit set to 8).
// Revision : 1.0  initial release
// ============================================================================
module tb_lsu;
    import lsu_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_load_en;
    logic [31:0] mem_load_addr;
    logic [4:0]  mem_load_regs_addr;
    logic        mem_store_en;
    logic [31:0] mem_store_addr;
    logic [31:0] mem_store_data;
    logic [2:0]  mem_funct3;
    logic        regs_write_en;
    logic [4:0]  regs_write_addr;
    logic [31:0] regs_write_data;
    logic        pause_signal;
    logic        unpause_signal;
    logic        bus_error;
`ifdef RUA_LSU_MISALIGN_TRAP_EN
    logic        misalign;
    logic [31:0] misalign_addr;
`endif

    int vectors     = 0;
    int miscompares = 0;

    lsu_if bus ();

    lsu #(.TIMEOUT_CYCLES(8)) dut (
        .clk                (clk),
        .rst                (rst),
        .dbus               (bus),
        .mem_load_en        (mem_load_en),
        .mem_load_addr      (mem_load_addr),
        .mem_load_regs_addr (mem_load_regs_addr),
        .mem_store_en       (mem_store_en),
        .mem_store_addr     (mem_store_addr),
        .mem_store_data     (mem_store_data),
        .mem_funct3         (mem_funct3),
        .regs_write_en      (regs_write_en),
        .regs_write_addr    (regs_write_addr),
        .regs_write_data    (regs_write_data),
        .pause_signal       (pause_signal),
        .unpause_signal     (unpause_signal),
        .bus_error          (bus_error)
`ifdef RUA_LSU_MISALIGN_TRAP_EN
        ,
        .misalign           (misalign),
        .misalign_addr      (misalign_addr)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    // Present a request for one sampling cycle; returns in the following cycle.
    task automatic start_store(input logic [31:0] a, input logic [31:0] d, input logic [2:0] f3);
        mem_store_en   = 1'b1;
        mem_store_addr = a;
        mem_store_data = d;
        mem_funct3     = f3;
        settle();
        chk("pause_on_sample", pause_signal, 1'b1);
        tick();
        mem_store_en = 1'b0;
        settle();
    endtask

    task automatic start_load(input logic [31:0] a, input logic [4:0] rd, input logic [2:0] f3);
        mem_load_en        = 1'b1;
        mem_load_addr      = a;
        mem_load_regs_addr = rd;
        mem_funct3         = f3;
        settle();
        chk("pause_on_sample", pause_signal, 1'b1);
        tick();
        mem_load_en = 1'b0;
        settle();
    endtask

    // Fast load (ready=1, resp one cycle later); returns in the DONE cycle.
    task automatic run_load(input logic [31:0] a, input logic [4:0] rd, input logic [2:0] f3,
                            input logic [31:0] word);
        bus.dbus_req_ready = 1'b1;
        start_load(a, rd, f3);
        chk("ld_req_valid", bus.dbus_req_valid, 1'b1);
        chk("ld_req_addr", bus.dbus_req_addr, {a[31:2], 2'b00});
        chk("ld_req_we", bus.dbus_req_we, 1'b0);
        tick();
        bus.dbus_resp_valid = 1'b1;
        bus.dbus_resp_rdata = word;
        settle();
        chk("ld_wait_pause", pause_signal, 1'b1);
        tick();
        bus.dbus_resp_valid = 1'b0;
        bus.dbus_resp_rdata = 32'h0;
        settle();
        chk("ld_done_unpause", unpause_signal, 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout observed=hang expected=finish");
        $fatal(1, "bench did not finish");
    end

    initial begin
        rst                 = 1'b1;
        mem_load_en         = 1'b0;
        mem_load_addr       = 32'h0;
        mem_load_regs_addr  = 5'd0;
        mem_store_en        = 1'b0;
        mem_store_addr      = 32'h0;
        mem_store_data      = 32'h0;
        mem_funct3          = 3'b000;
        bus.dbus_req_ready  = 1'b0;
        bus.dbus_resp_valid = 1'b0;
        bus.dbus_resp_rdata = 32'h0;
        tick();
        tick();
        rst = 1'b0;
        settle();
        chk("rst_req_valid", bus.dbus_req_valid, 1'b0);
        chk("rst_pause", pause_signal, 1'b0);
        chk("rst_unpause", unpause_signal, 1'b0);
        chk("rst_regs_we", regs_write_en, 1'b0);
        chk("rst_bus_error", bus_error, 1'b0);
        chk("rst_wstrb", bus.dbus_req_wstrb, 4'h0);
        tick();

        // SW, ready high: one request cycle, DONE at T+2
        bus.dbus_req_ready = 1'b1;
        start_store(32'h104, 32'hDEADBEEF, INST_FUNCT3_SW);
        chk("sw_req_valid", bus.dbus_req_valid, 1'b1);
        chk("sw_req_we", bus.dbus_req_we, 1'b1);
        chk("sw_req_addr", bus.dbus_req_addr, 32'h104);
        chk("sw_wstrb", bus.dbus_req_wstrb, 4'b1111);
        chk("sw_wdata", bus.dbus_req_wdata, 32'hDEADBEEF);
        chk("sw_no_early_unpause", unpause_signal, 1'b0);
        tick(); settle();
        chk("sw_unpause_t2", unpause_signal, 1'b1);
        chk("sw_req_valid_drop", bus.dbus_req_valid, 1'b0);
        chk("sw_done_pause", pause_signal, 1'b0);
        chk("sw_no_regs_we", regs_write_en, 1'b0);
        tick(); settle();
        chk("sw_unpause_one_cycle", unpause_signal, 1'b0);

        // SB to byte 3
        start_store(32'h103, 32'h000000A5, INST_FUNCT3_SB);
        chk("sb_wstrb", bus.dbus_req_wstrb, 4'b1000);
        chk("sb_wdata", bus.dbus_req_wdata, 32'hA5A5A5A5);
        chk("sb_req_addr", bus.dbus_req_addr, 32'h100);
        tick(); settle();
        chk("sb_unpause", unpause_signal, 1'b1);
        chk("sb_no_regs_we", regs_write_en, 1'b0);
        tick();

        // SH to upper half
        start_store(32'h106, 32'h1234ABCD, INST_FUNCT3_SH);
        chk("sh_wstrb", bus.dbus_req_wstrb, 4'b1100);
        chk("sh_wdata", bus.dbus_req_wdata, 32'hABCDABCD);
        tick(); tick();

        // LB / LBU from byte 2
        run_load(32'h102, 5'd5, INST_FUNCT3_LB, 32'h0080FF00);
        chk("lb_regs_we", regs_write_en, 1'b1);
        chk("lb_regs_addr", regs_write_addr, 5'd5);
        chk("lb_regs_data", regs_write_data, 32'hFFFFFF80);
        tick(); settle();
        chk("lb_we_one_cycle", regs_write_en, 1'b0);
        run_load(32'h102, 5'd5, INST_FUNCT3_LBU, 32'h0080FF00);
        chk("lbu_regs_data", regs_write_data, 32'h00000080);
        tick();

        // LH to x0: bus read still happens (checked in run_load), no writeback
        run_load(32'h102, 5'd0, INST_FUNCT3_LH, 32'h80011234);
        chk("lh_x0_no_we", regs_write_en, 1'b0);
        tick();

        // LH with ready low three cycles and response two cycles late
        bus.dbus_req_ready = 1'b0;
        start_load(32'h102, 5'd7, INST_FUNCT3_LH);
        for (int i = 0; i < 3; i++) begin
            chk("stall_req_valid", bus.dbus_req_valid, 1'b1);
            chk("stall_req_addr", bus.dbus_req_addr, 32'h100);
            chk("stall_pause", pause_signal, 1'b1);
            tick(); settle();
        end
        bus.dbus_req_ready = 1'b1;
        chk("stall_req_valid_acc", bus.dbus_req_valid, 1'b1);
        tick();
        bus.dbus_req_ready = 1'b0;
        settle();
        chk("stall_wait_pause0", pause_signal, 1'b1);
        tick(); settle();
        chk("stall_wait_pause1", pause_signal, 1'b1);
        tick();
        bus.dbus_resp_valid = 1'b1;
        bus.dbus_resp_rdata = 32'h80011234;
        settle();
        chk("stall_resp_no_we", regs_write_en, 1'b0);
        tick();
        bus.dbus_resp_valid = 1'b0;
        settle();
        chk("stall_regs_we", regs_write_en, 1'b1);
        chk("stall_regs_addr", regs_write_addr, 5'd7);
        chk("stall_regs_data", regs_write_data, 32'hFFFF8001);
        chk("stall_unpause", unpause_signal, 1'b1);
        tick();

        // Same load, reset while waiting for the response
        start_load(32'h102, 5'd7, INST_FUNCT3_LH);
        for (int i = 0; i < 3; i++) tick();
        bus.dbus_req_ready = 1'b1;
        tick();
        bus.dbus_req_ready = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        bus.dbus_resp_valid = 1'b1;
        settle();
        chk("rstmid_pause", pause_signal, 1'b0);
        chk("rstmid_req_valid", bus.dbus_req_valid, 1'b0);
        chk("rstmid_unpause", unpause_signal, 1'b0);
        tick();
        bus.dbus_resp_valid = 1'b0;
        settle();
        chk("rstmid_no_we", regs_write_en, 1'b0);
        chk("rstmid_no_unpause", unpause_signal, 1'b0);
        tick();

        // Load and store together: load wins
        bus.dbus_req_ready = 1'b1;
        mem_store_en       = 1'b1;
        mem_store_addr     = 32'h300;
        run_load(32'h208, 5'd3, INST_FUNCT3_LW, 32'hCAFEF00D);
        chk("both_regs_we", regs_write_en, 1'b1);
        chk("both_regs_data", regs_write_data, 32'hCAFEF00D);
        tick();

        // Unsupported funct3: straight to DONE, no bus access
        start_load(32'h100, 5'd4, 3'b011);
        chk("badf3_ld_unpause", unpause_signal, 1'b1);
        chk("badf3_ld_no_req", bus.dbus_req_valid, 1'b0);
        chk("badf3_ld_no_we", regs_write_en, 1'b0);
        tick();
        start_store(32'h100, 32'h55, INST_FUNCT3_LBU);
        chk("badf3_st_unpause", unpause_signal, 1'b1);
        chk("badf3_st_no_req", bus.dbus_req_valid, 1'b0);
        tick();

        // Watchdog on a store whose request is never accepted
        bus.dbus_req_ready = 1'b0;
        start_store(32'h200, 32'h11, INST_FUNCT3_SW);
        for (int i = 1; i < 8; i++) begin
            chk("wd_st_no_err", bus_error, 1'b0);
            tick(); settle();
        end
        chk("wd_st_err_8th", bus_error, 1'b1);
        chk("wd_st_no_unpause", unpause_signal, 1'b0);
        tick(); settle();
        chk("wd_st_unpause", unpause_signal, 1'b1);
        chk("wd_st_err_pulse", bus_error, 1'b0);
        tick();

        // Watchdog on a load that never gets a response
        bus.dbus_req_ready = 1'b1;
        start_load(32'h100, 5'd9, INST_FUNCT3_LW);
        for (int i = 1; i < 8; i++) begin
            chk("wd_ld_no_err", bus_error, 1'b0);
            tick();
            bus.dbus_req_ready = 1'b0;
            settle();
        end
        chk("wd_ld_err_8th", bus_error, 1'b1);
        tick(); settle();
        chk("wd_ld_unpause", unpause_signal, 1'b1);
        chk("wd_ld_no_we", regs_write_en, 1'b0);
        tick();

`ifdef RUA_LSU_MISALIGN_TRAP_EN
        start_load(32'h102, 5'd6, INST_FUNCT3_LW);
        chk("mis_flag", misalign, 1'b1);
        chk("mis_addr", misalign_addr, 32'h102);
        chk("mis_no_req", bus.dbus_req_valid, 1'b0);
        chk("mis_no_we", regs_write_en, 1'b0);
        tick();
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
